// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the segmented pipelined add/subtract unit:
// operation mode encodings, default widths and the stage-count helper.
package pipelined_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_ADDER_SIZE = 32;
  localparam int DEF_SEG_SIZE   = 8;

  function automatic int stage_count(input int adder_size, input int seg_size);
    return adder_size / seg_size;
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: adds segment IDX using the carry registered by the
// previous stage and registers carry, operands, partial result and flags.
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int ADDER_SIZE = DEF_ADDER_SIZE,
  parameter int SEG_SIZE   = DEF_SEG_SIZE,
  parameter int IDX        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_advance,
  input  logic                  i_valid,
  input  logic                  i_carry,
  input  logic                  i_zero,
  input  logic [ADDER_SIZE-1:0] i_a,
  input  logic [ADDER_SIZE-1:0] i_b,
  input  logic [ADDER_SIZE-1:0] i_res,
  output logic                  o_valid,
  output logic                  o_carry,
  output logic                  o_zero,
  output logic                  o_overflow,
  output logic [ADDER_SIZE-1:0] o_a,
  output logic [ADDER_SIZE-1:0] o_b,
  output logic [ADDER_SIZE-1:0] o_res
);

  localparam int OFF = IDX * SEG_SIZE;
  localparam int MSB = OFF + SEG_SIZE - 1;

  logic [SEG_SIZE:0]     w_sum;
  logic [ADDER_SIZE-1:0] w_res;
  logic                  w_cin_msb;

  logic                  r_valid;
  logic                  r_carry;
  logic                  r_zero;
  logic                  r_overflow;
  logic [ADDER_SIZE-1:0] r_a;
  logic [ADDER_SIZE-1:0] r_b;
  logic [ADDER_SIZE-1:0] r_res;

  assign w_sum = {1'b0, i_a[OFF +: SEG_SIZE]} + {1'b0, i_b[OFF +: SEG_SIZE]}
               + {{SEG_SIZE{1'b0}}, i_carry};
  // Segment bits of i_res are still zero here, so OR-ing the new segment in is exact.
  assign w_res = i_res | (ADDER_SIZE'(w_sum[SEG_SIZE-1:0]) << OFF);
  assign w_cin_msb = i_a[MSB] ^ i_b[MSB] ^ w_sum[SEG_SIZE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      // Bubbles leave the data registers alone so outputs stay quiet between results.
      if (i_valid) begin
        r_carry    <= w_sum[SEG_SIZE];
        r_zero     <= i_zero && (w_sum[SEG_SIZE-1:0] == '0);
        r_overflow <= w_cin_msb ^ w_sum[SEG_SIZE];
        r_a        <= i_a;
        r_b        <= i_b;
        r_res      <= w_res;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_carry    = r_carry;
  assign o_zero     = r_zero;
  assign o_overflow = r_overflow;
  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_res      = r_res;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: STAGES carry-registered segments behind a
// valid/ready handshake with one global stall signal.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int ADDER_SIZE = DEF_ADDER_SIZE,
  parameter int SEG_SIZE   = DEF_SEG_SIZE
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  mode,
  input  logic [ADDER_SIZE-1:0] dIn0,
  input  logic [ADDER_SIZE-1:0] dIn1,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ADDER_SIZE-1:0] dOut,
  output logic                  overflow,
  output logic                  carryOut,
  output logic                  zero
);

  localparam int STAGES = stage_count(ADDER_SIZE, SEG_SIZE);

  if (ADDER_SIZE % SEG_SIZE != 0) begin : g_size_check
    $error("pipelined_adder: ADDER_SIZE must be a multiple of SEG_SIZE");
  end

  logic                  w_advance;
  logic                  w_sub;

  logic [STAGES-1:0]     w_in_valid;
  logic [STAGES-1:0]     w_in_carry;
  logic [STAGES-1:0]     w_in_zero;
  logic [ADDER_SIZE-1:0] w_in_a   [STAGES];
  logic [ADDER_SIZE-1:0] w_in_b   [STAGES];
  logic [ADDER_SIZE-1:0] w_in_res [STAGES];

  logic [STAGES-1:0]     w_valid;
  logic [STAGES-1:0]     w_carry;
  logic [STAGES-1:0]     w_zero;
  logic [STAGES-1:0]     w_ovf;
  logic [ADDER_SIZE-1:0] w_a   [STAGES];
  logic [ADDER_SIZE-1:0] w_b   [STAGES];
  logic [ADDER_SIZE-1:0] w_res [STAGES];

  assign w_advance = !outValid || outReady;
  assign inReady   = w_advance;
  assign w_sub     = (mode == MODE_SUB);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // Subtraction is a + ~b + 1, with the +1 entering as segment 0's carry-in.
      assign w_in_valid[gi] = inValid;
      assign w_in_carry[gi] = w_sub;
      assign w_in_zero[gi]  = 1'b1;
      assign w_in_a[gi]     = dIn0;
      assign w_in_b[gi]     = w_sub ? ~dIn1 : dIn1;
      assign w_in_res[gi]   = '0;
    end else begin : g_chain
      assign w_in_valid[gi] = w_valid[gi-1];
      assign w_in_carry[gi] = w_carry[gi-1];
      assign w_in_zero[gi]  = w_zero[gi-1];
      assign w_in_a[gi]     = w_a[gi-1];
      assign w_in_b[gi]     = w_b[gi-1];
      assign w_in_res[gi]   = w_res[gi-1];
    end

    pipelined_adder_stage #(
      .ADDER_SIZE (ADDER_SIZE),
      .SEG_SIZE   (SEG_SIZE),
      .IDX        (gi)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rstN),
      .i_flush    (flush),
      .i_advance  (w_advance),
      .i_valid    (w_in_valid[gi]),
      .i_carry    (w_in_carry[gi]),
      .i_zero     (w_in_zero[gi]),
      .i_a        (w_in_a[gi]),
      .i_b        (w_in_b[gi]),
      .i_res      (w_in_res[gi]),
      .o_valid    (w_valid[gi]),
      .o_carry    (w_carry[gi]),
      .o_zero     (w_zero[gi]),
      .o_overflow (w_ovf[gi]),
      .o_a        (w_a[gi]),
      .o_b        (w_b[gi]),
      .o_res      (w_res[gi])
    );
  end

  assign outValid = w_valid[STAGES-1];
  assign dOut     = w_res[STAGES-1];
  assign carryOut = w_carry[STAGES-1];
  assign overflow = w_ovf[STAGES-1];
  assign zero     = w_zero[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder against a queue-based
// arithmetic reference model; a second instance covers the single-stage build.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    logic        c;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [31:0] d0;
  logic [31:0] d1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        ovf;
  logic        cout;
  logic        zero;

  logic        flush1;
  logic        in1_valid;
  logic        in1_ready;
  logic        mode1;
  logic [31:0] d1_0;
  logic [31:0] d1_1;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] d1_out;
  logic        ovf1;
  logic        cout1;
  logic        zero1;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  res_t        exp_q[$];
  logic [31:0] got_log[$];
  logic        log_en    = 1'b0;
  logic        hold_pend = 1'b0;
  logic [39:0] hold_val;

  always #5 clk = ~clk;

  pipelined_adder #(.ADDER_SIZE(32), .SEG_SIZE(8)) dut (
    .clk(clk), .rstN(rstN), .flush(flush), .inValid(in_valid), .inReady(in_ready),
    .mode(mode), .dIn0(d0), .dIn1(d1), .outValid(out_valid), .outReady(out_ready),
    .dOut(d_out), .overflow(ovf), .carryOut(cout), .zero(zero)
  );

  pipelined_adder #(.ADDER_SIZE(32), .SEG_SIZE(32)) dut1 (
    .clk(clk), .rstN(rstN), .flush(flush1), .inValid(in1_valid), .inReady(in1_ready),
    .mode(mode1), .dIn0(d1_0), .dIn1(d1_1), .outValid(out1_valid), .outReady(out1_ready),
    .dOut(d1_out), .overflow(ovf1), .carryOut(cout1), .zero(zero1)
  );

  // Reference: plain 32-bit arithmetic, flags from the operand/result sign rules.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic m);
    res_t        r;
    logic [32:0] w;
    if (m) begin
      r.d = a - b;
      r.c = (a >= b);
      r.o = (a[31] != b[31]) && (r.d[31] != a[31]);
    end else begin
      w   = {1'b0, a} + {1'b0, b};
      r.d = w[31:0];
      r.c = w[32];
      r.o = (a[31] == b[31]) && (r.d[31] != a[31]);
    end
    r.z = (r.d == 32'd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h", nm, got, exp);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Single compare process: checks every observable cycle against the model queue.
  always @(negedge clk) begin
    if (!rstN) begin
      chk("rst_valid", 40'(out_valid), 40'd0);
      chk("rst_dout", 40'(d_out), 40'd0);
      chk("rst_flags", 40'({ovf, cout, zero}), 40'd0);
      chk("rst_inready", 40'(in_ready), 40'd1);
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      chk("inready_rule", 40'(in_ready), 40'(!out_valid || out_ready));
      if (hold_pend) chk("out_hold", 40'({d_out, ovf, cout, zero}), hold_val);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_result got=%h expected no result", d_out);
        end else begin
          chk("result", 40'({d_out, ovf, cout, zero}),
              40'({exp_q[0].d, exp_q[0].o, exp_q[0].c, exp_q[0].z}));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (log_en) got_log.push_back(d_out);
          end
        end
      end
      hold_pend = out_valid && !out_ready && !flush;
      hold_val  = 40'({d_out, ovf, cout, zero});
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(d0, d1, mode));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m);
    bit ok = 1'b0;
    in_valid = 1'b1;
    d0 = a;
    d1 = b;
    mode = m;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk_cnt++;
      $display("FAIL send_timeout got=inReady 0 expected=inReady 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic [31:0] ed, input logic eo,
                         input logic ec, input logic ez);
    int lat = 0;
    @(posedge clk);
    #1;
    send(a, b, m);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({nm, "_latency"}, 40'(lat), 40'd4);
    chk({nm, "_dout"}, 40'(d_out), 40'(ed));
    chk({nm, "_flags"}, 40'({ovf, cout, zero}), 40'({eo, ec, ez}));
  endtask

  task automatic check_silent(input string nm);
    int seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(nm, 40'(seen), 40'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rstN = 1'b0; flush = 1'b0; in_valid = 1'b0; mode = 1'b0; d0 = '0; d1 = '0; out_ready = 1'b1;
    flush1 = 1'b0; in1_valid = 1'b0; mode1 = 1'b0; d1_0 = '0; d1_1 = '0; out1_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rstN = 1'b1;

    run_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_one("add_carry",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    run_one("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Six back-to-back adds with a three-cycle consumer stall after the first result.
    repeat (3) @(posedge clk);
    got_log.delete();
    log_en = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) send(32'(i), 32'd1, 1'b0);
      end
      begin
        logic [31:0] held = '0;
        for (int n = 0; n < 30; n++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk);
        #2 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (k == 0) held = d_out;
          else chk("stall_dout_stable", 40'(d_out), 40'(held));
          chk("stall_inready", 40'(in_ready), 40'd0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    repeat (15) @(posedge clk);
    log_en = 1'b0;
    chk("stream_count", 40'(got_log.size()), 40'd6);
    for (int i = 0; i < got_log.size() && i < 6; i++) chk("stream_order", 40'(got_log[i]), 40'(i + 1));

    // Asynchronous reset with three operations in flight.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(32'(10 + i), 32'(i), 1'b0);
    #3 rstN = 1'b0;
    #1 chk("rst_async_inready", 40'(in_ready), 40'd1);
    @(posedge clk);
    #3 rstN = 1'b1;
    check_silent("rst_no_result");
    run_one("after_rst", 32'h0000_1000, 32'h0000_0234, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0);

    // Reset while a result is on the output: outValid must drop without a clock edge.
    @(posedge clk);
    #1;
    send(32'h0000_0042, 32'h0000_0001, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    #2 rstN = 1'b0;
    #1 chk("rst_async_valid", 40'({out_valid, d_out}), 40'd0);
    @(posedge clk);
    #3 rstN = 1'b1;

    // Flush with three in flight, plus a dropped input in the flush cycle.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(32'(20 + i), 32'(i), 1'b1);
    flush = 1'b1; in_valid = 1'b1; d0 = 32'd99; d1 = 32'd1; mode = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check_silent("flush_no_result");
    run_one("after_flush", 32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with random back-pressure and occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      mode      = 1'($urandom_range(0, 1));
      d0        = rand_val();
      d1        = rand_val();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("drain_empty", 40'(exp_q.size()), 40'd0);

    // Single-stage build: result one cycle after accept.
    @(posedge clk);
    #1 in1_valid = 1'b1; d1_0 = 32'h1234_5678; d1_1 = 32'h1111_1111;
    @(posedge clk);
    #1 in1_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out1_valid) begin
        lat = n;
        break;
      end
    end
    chk("single_latency", 40'(lat), 40'd1);
    chk("single_dout", 40'(d1_out), 40'h0023456789);
    chk("single_flags", 40'({ovf1, cout1, zero1}), 40'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
